// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU and response signals of the two-requester ALU arbiter.
//   req0_*/req1_*         : valid/ready handshake, operands a/b, RV32I instruction word
//   alu_a/alu_b/alu_inst  : registered operands and instruction to the external ALU
//   alu_result/alu_take_b : combinational ALU outputs
//   rsp_*                 : valid/ready response carrying requester id, result and take_b
// master = requesters + ALU + response consumer; slave = the arbiter.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [31:0] req0_inst;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [31:0] req1_inst;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_inst;
  logic [31:0] alu_result;
  logic        alu_take_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_take_b;

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req0_inst, req1_a, req1_b, req1_inst,
    output alu_result, alu_take_b, rsp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_inst,
    input  rsp_valid, rsp_id, rsp_result, rsp_take_b
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req0_inst, req1_a, req1_b, req1_inst,
    input  alu_result, alu_take_b, rsp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_inst,
    output rsp_valid, rsp_id, rsp_result, rsp_take_b
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// One operation in flight: grant in IDLE, sample ALU in EXEC, hold response in RESP.
//   clk : sole clock (rising edge)
//   rst : asynchronous active-high reset
//   bus : alu_arbiter_if slave modport (requests, ALU operands/results, response)
// RR_EN = 1 alternates grants under contention, 0 always favours requester 0.
//
// state | meaning
// IDLE  | waiting; grants one valid requester and captures its operands
// EXEC  | ALU evaluating captured operands; result sampled at end of cycle
// RESP  | rsp_valid high, response held until rsp_ready
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q;
  state_t      state_d;
  logic        grant;
  logic        grant_id;
  logic        last_grant_q;
  logic        rsp_id_q;
  logic        rsp_take_b_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [31:0] alu_inst_q;
  logic [31:0] rsp_result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    grant_id = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          grant = 1'b1;
          // under contention, round-robin picks whoever did not win last time
          if (bus.req0_valid && bus.req1_valid) grant_id = RR_EN ? ~last_grant_q : 1'b0;
          else                                  grant_id = bus.req1_valid;
          state_d = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_take_b_q <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_inst_q   <= '0;
      rsp_result_q <= '0;
    end else begin
      if (grant) begin
        last_grant_q <= grant_id;
        rsp_id_q     <= grant_id;
        alu_a_q      <= grant_id ? bus.req1_a    : bus.req0_a;
        alu_b_q      <= grant_id ? bus.req1_b    : bus.req0_b;
        alu_inst_q   <= grant_id ? bus.req1_inst : bus.req0_inst;
      end
      if (state_q == EXEC) begin
        rsp_result_q <= bus.alu_result;
        rsp_take_b_q <= bus.alu_take_b;
      end
    end
  end

  // ready is combinational from the grant; masked by rst so it drops the moment reset rises
  assign bus.req0_ready = grant & ~grant_id & ~rst;
  assign bus.req1_ready = grant &  grant_id & ~rst;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_inst   = alu_inst_q;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_take_b = rsp_take_b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two arbiters (round-robin and fixed priority) share one stimulus
// stream; each is compared every cycle with a transaction-level reference model.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if if_rr ();
  alu_arbiter_if if_fp ();

  alu_arbiter #(.RR_EN(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(if_rr));
  alu_arbiter #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(if_fp));

  // RV32I ALU: R/I-type arithmetic and branch compare
  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] inst);
    logic [31:0] y;
    logic        tk;
    y  = '0;
    tk = 1'b0;
    case (inst[6:0])
      7'h33, 7'h13: begin
        case (inst[14:12])
          3'd0:    y = (inst[6:0] == 7'h33 && inst[30]) ? a - b : a + b;
          3'd1:    y = a << b[4:0];
          3'd2:    y = {31'd0, $signed(a) < $signed(b)};
          3'd3:    y = {31'd0, a < b};
          3'd4:    y = a ^ b;
          3'd5:    y = inst[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'd6:    y = a | b;
          default: y = a & b;
        endcase
      end
      7'h63: begin
        y = a - b;
        case (inst[14:12])
          3'd0:    tk = (a == b);
          3'd1:    tk = (a != b);
          3'd4:    tk = $signed(a) <  $signed(b);
          3'd5:    tk = $signed(a) >= $signed(b);
          3'd6:    tk = a <  b;
          3'd7:    tk = a >= b;
          default: tk = 1'b0;
        endcase
      end
      default: y = '0;
    endcase
    return {tk, y};
  endfunction

  assign {if_rr.alu_take_b, if_rr.alu_result} = alu_model(if_rr.alu_a, if_rr.alu_b, if_rr.alu_inst);
  assign {if_fp.alu_take_b, if_fp.alu_result} = alu_model(if_fp.alu_a, if_fp.alu_b, if_fp.alu_inst);

  assign if_fp.req0_valid = if_rr.req0_valid;
  assign if_fp.req1_valid = if_rr.req1_valid;
  assign if_fp.req0_a     = if_rr.req0_a;
  assign if_fp.req0_b     = if_rr.req0_b;
  assign if_fp.req0_inst  = if_rr.req0_inst;
  assign if_fp.req1_a     = if_rr.req1_a;
  assign if_fp.req1_b     = if_rr.req1_b;
  assign if_fp.req1_inst  = if_rr.req1_inst;
  assign if_fp.rsp_ready  = if_rr.rsp_ready;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // observed outputs, index 0 = round-robin, 1 = fixed priority
  logic        o_rdy0[2], o_rdy1[2], o_rv[2], o_id[2], o_tk[2];
  logic [31:0] o_res[2], o_a[2], o_b[2], o_i[2];

  task automatic read_obs();
    o_rdy0[0] = if_rr.req0_ready; o_rdy0[1] = if_fp.req0_ready;
    o_rdy1[0] = if_rr.req1_ready; o_rdy1[1] = if_fp.req1_ready;
    o_rv[0]   = if_rr.rsp_valid;  o_rv[1]   = if_fp.rsp_valid;
    o_id[0]   = if_rr.rsp_id;     o_id[1]   = if_fp.rsp_id;
    o_tk[0]   = if_rr.rsp_take_b; o_tk[1]   = if_fp.rsp_take_b;
    o_res[0]  = if_rr.rsp_result; o_res[1]  = if_fp.rsp_result;
    o_a[0]    = if_rr.alu_a;      o_a[1]    = if_fp.alu_a;
    o_b[0]    = if_rr.alu_b;      o_b[1]    = if_fp.alu_b;
    o_i[0]    = if_rr.alu_inst;   o_i[1]    = if_fp.alu_inst;
  endtask

  // reference model: one pending operation per arbiter, identified by its grant cycle
  bit          m_pend[2];
  int          m_gcyc[2];
  bit          m_last[2];
  bit          m_id[2];
  bit          m_tk[2];
  logic [31:0] m_a[2], m_b[2], m_i[2], m_res[2];

  int          g_log[$];
  logic [31:0] r_log[$];
  int          fp_g0 = 0;
  int          fp_g1 = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 1'b0; m_last[k] = 1'b1; m_id[k] = 1'b0; m_tk[k] = 1'b0;
      m_a[k] = '0; m_b[k] = '0; m_i[k] = '0; m_res[k] = '0; m_gcyc[k] = 0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    read_obs();
    for (int k = 0; k < 2; k++) begin
      string nm;
      nm = (k == 0) ? {tag, ".rr"} : {tag, ".fp"};
      chk({nm, ".req0_ready"}, 32'(o_rdy0[k]), 32'd0);
      chk({nm, ".req1_ready"}, 32'(o_rdy1[k]), 32'd0);
      chk({nm, ".rsp_valid"},  32'(o_rv[k]),   32'd0);
      chk({nm, ".rsp_id"},     32'(o_id[k]),   32'd0);
      chk({nm, ".rsp_take_b"}, 32'(o_tk[k]),   32'd0);
      chk({nm, ".rsp_result"}, o_res[k],       32'd0);
      chk({nm, ".alu_a"},      o_a[k],         32'd0);
      chk({nm, ".alu_b"},      o_b[k],         32'd0);
      chk({nm, ".alu_inst"},   o_i[k],         32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    if_rr.req0_valid = 1'b0;
    if_rr.req1_valid = 1'b0;
    if_rr.rsp_ready  = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // one clock cycle: drive inputs, check every output against the model, advance the model
  task automatic step(input bit v0, input bit v1,
                      input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] i0,
                      input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] i1,
                      input bit rdy);
    @(negedge clk);
    if_rr.req0_valid = v0; if_rr.req1_valid = v1;
    if_rr.req0_a = a0; if_rr.req0_b = b0; if_rr.req0_inst = i0;
    if_rr.req1_a = a1; if_rr.req1_b = b1; if_rr.req1_inst = i1;
    if_rr.rsp_ready = rdy;
    #1;
    read_obs();
    for (int k = 0; k < 2; k++) begin
      bit          eg, eid, erv;
      logic [32:0] r;
      string       nm;
      nm  = (k == 0) ? "rr" : "fp";
      eg  = !m_pend[k] && (v0 || v1);
      if (v0 && v1) eid = (k == 0) ? ~m_last[k] : 1'b0;
      else          eid = v1;
      erv = m_pend[k] && (cyc >= m_gcyc[k] + 2);
      chk({nm, ".req0_ready"}, 32'(o_rdy0[k]), 32'(eg && !eid));
      chk({nm, ".req1_ready"}, 32'(o_rdy1[k]), 32'(eg && eid));
      chk({nm, ".rsp_valid"},  32'(o_rv[k]),   32'(erv));
      chk({nm, ".alu_a"},      o_a[k],         m_a[k]);
      chk({nm, ".alu_b"},      o_b[k],         m_b[k]);
      chk({nm, ".alu_inst"},   o_i[k],         m_i[k]);
      if (erv) begin
        chk({nm, ".rsp_id"},     32'(o_id[k]), 32'(m_id[k]));
        chk({nm, ".rsp_result"}, o_res[k],     m_res[k]);
        chk({nm, ".rsp_take_b"}, 32'(o_tk[k]), 32'(m_tk[k]));
      end
      if (eg) begin
        m_pend[k] = 1'b1;
        m_gcyc[k] = cyc;
        m_id[k]   = eid;
        m_last[k] = eid;
        m_a[k]    = eid ? a1 : a0;
        m_b[k]    = eid ? b1 : b0;
        m_i[k]    = eid ? i1 : i0;
        r         = alu_model(m_a[k], m_b[k], m_i[k]);
        m_res[k]  = r[31:0];
        m_tk[k]   = r[32];
      end else if (erv && rdy) begin
        m_pend[k] = 1'b0;
      end
    end
    if (o_rdy0[0]) g_log.push_back(0);
    if (o_rdy1[0]) g_log.push_back(1);
    if (o_rv[0] && rdy) r_log.push_back(o_res[0]);
    if (o_rdy0[1]) fp_g0++;
    if (o_rdy1[1]) fp_g1++;
    cyc++;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, rdy);
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [6:0] op;
    case ($urandom_range(2))
      0:       op = 7'h33;
      1:       op = 7'h13;
      default: op = 7'h63;
    endcase
    return {1'b0, 1'($urandom_range(1)), 5'($urandom), 5'($urandom), 5'($urandom),
            3'($urandom_range(7)), 5'($urandom), op};
  endfunction

  function automatic logic [31:0] rnd_opnd();
    return ($urandom_range(1) != 0) ? 32'($urandom) : 32'($urandom_range(15));
  endfunction

  int          exp_g[4] = '{0, 1, 0, 1};
  logic [31:0] exp_r[4] = '{32'd2, 32'd15, 32'd2, 32'd15};

  initial begin
    if_rr.req0_valid = 1'b0; if_rr.req1_valid = 1'b0; if_rr.rsp_ready = 1'b0;
    if_rr.req0_a = '0; if_rr.req0_b = '0; if_rr.req0_inst = '0;
    if_rr.req1_a = '0; if_rr.req1_b = '0; if_rr.req1_inst = '0;
    model_reset();
    do_reset();

    // single subtract from requester 0
    step(1'b1, 1'b0, 32'd5, 32'd3, 32'h4000_0033, '0, '0, '0, 1'b1);
    chk("sub.accept_ready0", 32'(o_rdy0[0]), 32'd1);
    idle(1'b1);
    chk("sub.no_early_valid", 32'(o_rv[0]), 32'd0);
    idle(1'b1);
    chk("sub.rsp_valid", 32'(o_rv[0]), 32'd1);
    chk("sub.rsp_id", 32'(o_id[0]), 32'd0);
    chk("sub.rsp_result", o_res[0], 32'd2);
    idle(1'b0);

    // continuous contention on add, responses consumed at once
    do_reset();
    g_log.delete(); r_log.delete(); fp_g0 = 0; fp_g1 = 0;
    repeat (12) step(1'b1, 1'b1, 32'd1, 32'd1, 32'h0000_0033, 32'd7, 32'd8, 32'h0000_0033, 1'b1);
    chk("rr.grant_count", 32'(g_log.size()), 32'd4);
    chk("rr.result_count", 32'(r_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < g_log.size()) chk($sformatf("rr.grant%0d", i), 32'(g_log[i]), 32'(exp_g[i]));
      if (i < r_log.size()) chk($sformatf("rr.result%0d", i), r_log[i], exp_r[i]);
    end
    chk("fp.grants_req0", 32'(fp_g0), 32'd4);
    chk("fp.grants_req1", 32'(fp_g1), 32'd0);

    // beq with response backpressure, requesters keep asking
    do_reset();
    step(1'b1, 1'b0, 32'd9, 32'd9, 32'h0000_0063, '0, '0, '0, 1'b0);
    step(1'b1, 1'b1, 32'd1, 32'd2, 32'h0000_0033, 32'd3, 32'd4, 32'h0000_0033, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 32'd1, 32'd2, 32'h0000_0033, 32'd3, 32'd4, 32'h0000_0033, 1'b0);
      chk($sformatf("bp.rsp_valid%0d", i), 32'(o_rv[0]), 32'd1);
      chk($sformatf("bp.take_b%0d", i), 32'(o_tk[0]), 32'd1);
      chk($sformatf("bp.no_grant%0d", i), 32'(o_rdy0[0] | o_rdy1[0]), 32'd0);
    end
    step(1'b1, 1'b1, 32'd1, 32'd2, 32'h0000_0033, 32'd3, 32'd4, 32'h0000_0033, 1'b1);
    chk("bp.consume_no_grant", 32'(o_rdy0[0] | o_rdy1[0]), 32'd0);
    step(1'b1, 1'b1, 32'd1, 32'd2, 32'h0000_0033, 32'd3, 32'd4, 32'h0000_0033, 1'b1);
    chk("bp.regrant_req1", 32'(o_rdy1[0]), 32'd1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // reset while executing: nothing comes out, next contention goes to requester 0
    do_reset();
    step(1'b1, 1'b0, 32'd5, 32'd6, 32'h0000_0033, '0, '0, '0, 1'b1);
    @(posedge clk);
    #1;
    chk("mid.exec_alu_a", if_rr.alu_a, 32'd5);
    rst = 1'b1;
    #1;
    chk_all_zero("mid");
    if_rr.req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mid.no_rsp%0d", i), 32'(if_rr.rsp_valid | if_fp.rsp_valid), 32'd0);
    end
    rst = 1'b0;
    model_reset();
    step(1'b1, 1'b1, 32'd2, 32'd2, 32'h0000_0033, 32'd4, 32'd4, 32'h0000_0033, 1'b1);
    chk("mid.first_grant_req0", 32'(o_rdy0[0]), 32'd1);
    idle(1'b1);
    idle(1'b1);

    // random traffic with random backpressure
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(9) < 6, $urandom_range(9) < 6,
           rnd_opnd(), rnd_opnd(), rnd_inst(), rnd_opnd(), rnd_opnd(), rnd_inst(),
           $urandom_range(9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin grant and 0 = fixed priority to requester 0.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1  requester n presents an operation.
REQ-005 SHALL have ports req0_ready, req1_ready  output  1  operation of requester n accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  32  ALU operands of requester n.
REQ-007 SHALL have ports req0_inst, req1_inst  input  32  RV32I instruction word of requester n, passed to the ALU unmodified.
REQ-008 SHALL have ports alu_a, alu_b, alu_inst  output  32  registered operands and instruction driven to the external combinational ALU.
REQ-009 SHALL have ports alu_result  input  32  and alu_take_b  input  1  combinational ALU outputs.
REQ-010 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 (requester index), rsp_result  output  32, rsp_take_b  output  1.

Function
REQ-011 SHALL implement three states: IDLE, EXEC, RESP.
REQ-012 In IDLE, when at least one reqN_valid is high, SHALL grant exactly one requester, assert only that reqN_ready combinationally in the same cycle, capture its a/b/inst into the alu_* registers and its index into rsp_id, and go to EXEC.
REQ-013 In IDLE with no valid request, SHALL assert no reqN_ready and stay in IDLE.
REQ-014 reqN_ready SHALL be low in EXEC and RESP, regardless of reqN_valid.
REQ-015 Grant with one valid request SHALL go to that requester.
REQ-016 Grant with both requests valid and RR_EN=1 SHALL go to the requester not granted last (last_grant register).
REQ-017 Grant with both requests valid and RR_EN=0 SHALL always go to requester 0.
REQ-018 last_grant SHALL update only on a grant.
REQ-019 In EXEC (exactly one cycle), SHALL register alu_result into rsp_result and alu_take_b into rsp_take_b, then go to RESP.
REQ-020 In RESP, rsp_valid SHALL be 1; rsp_valid SHALL be 0 in all other states.
REQ-021 In RESP, rsp_result, rsp_take_b and rsp_id SHALL stay stable while rsp_ready is low.
REQ-022 In RESP with rsp_ready high, the response SHALL be consumed and the state SHALL return to IDLE; a new grant is possible in the following cycle.
REQ-023 Latency: accept at edge N, rsp_valid high after edge N+2.
REQ-024 Throughput: at most one operation per 3 cycles.
REQ-025 alu_a, alu_b and alu_inst SHALL hold their last captured values in RESP and IDLE and change only on a grant.
REQ-026 rsp_ready high outside RESP SHALL be ignored.
REQ-027 A requester dropping valid while not granted SHALL lose nothing and leave no side effect.
REQ-028 A request that keeps valid held after its grant SHALL be treated as a new request.

Reset
REQ-029 While rst is high, SHALL force state to IDLE, last_grant to 1 (so requester 0 wins the first contention), and alu_a, alu_b, alu_inst, rsp_result to 0; rsp_take_b, rsp_id, rsp_valid, req0_ready and req1_ready SHALL be 0.
REQ-030 rst asserted in EXEC or RESP SHALL discard the in-flight operation with no response produced; operation resumes from IDLE on the first edge after rst falls.

Verification
REQ-031 Single request, bench ALU = team ALU, sub: req0 a=5, b=3, inst=0x40000033 -> req0_ready high in the accept cycle, rsp_valid after 2 edges, rsp_id=0, rsp_result=2.
REQ-032 Contention, RR_EN=1, both valid every cycle, add: req0 a=1, b=1; req1 a=7, b=8; inst=0x00000033 -> grants alternate 0,1,0,1; results 2,15,2,15.
REQ-033 Contention, RR_EN=0, both valid -> every grant goes to requester 0 and req1_ready never asserts.
REQ-034 Backpressure, beq: a=b=9, inst=0x00000063, rsp_ready low for 4 cycles -> rsp_valid held, rsp_take_b=1 stable, no new grant until one cycle after rsp_ready rises.
REQ-035 Mid-flight reset: assert rst during EXEC -> rsp_valid never rises; all outputs 0 immediately (asynchronous); first request after release is granted to requester 0.
